// File: rtl/router_fifo.sv
// Per-port router output FIFO: 16 x {header flag, byte} with packet-length tracking on the read side.
// Optional occupancy output when ROUTER_FIFO_OCC_EN is defined.
module router_fifo (
    input  logic       clk,
    input  logic       rst,
    input  logic       soft_reset,
    input  logic       wr_en,
    input  logic       rd_en,
    input  logic       lfd_state,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       full,
    output logic       empty,
`ifdef ROUTER_FIFO_OCC_EN
    output logic [4:0] occupancy,
`endif
    output logic       pkt_busy
);

    logic [8:0] mem_q [16];
    logic [8:0] mem_d [16];
    logic [4:0] wr_ptr_q, wr_ptr_d;
    logic [4:0] rd_ptr_q, rd_ptr_d;
    logic [6:0] cnt_q, cnt_d;
    logic [7:0] data_out_q, data_out_d;
    logic       pkt_busy_q, pkt_busy_d;
    logic       do_wr_s;
    logic       do_rd_s;
    logic [8:0] rd_entry_s;

    assign full     = (wr_ptr_q[3:0] == rd_ptr_q[3:0]) && (wr_ptr_q[4] != rd_ptr_q[4]);
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign data_out = data_out_q;
    assign pkt_busy = pkt_busy_q;
`ifdef ROUTER_FIFO_OCC_EN
    assign occupancy = wr_ptr_q - rd_ptr_q;
`endif

    assign do_wr_s    = wr_en & ~full;
    assign do_rd_s    = rd_en & ~empty;
    assign rd_entry_s = mem_q[rd_ptr_q[3:0]];

    // Next-state: soft flush, then independent write and read sides
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        data_out_d = data_out_q;
        if (soft_reset) begin
            for (int i = 0; i < 16; i++) begin
                mem_d[i] = 9'h000;
            end
            wr_ptr_d   = 5'd0;
            rd_ptr_d   = 5'd0;
            cnt_d      = 7'd0;
            data_out_d = 8'h00;
        end else begin
            if (do_wr_s) begin
                mem_d[wr_ptr_q[3:0]] = {lfd_state, data_in};
                wr_ptr_d             = wr_ptr_q + 5'd1;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_rd_s) begin
                data_out_d = rd_entry_s[7:0];
                rd_ptr_d   = rd_ptr_q + 5'd1;
                // Header carries payload length in [7:2]; +1 accounts for the parity byte
                if (rd_entry_s[8]) begin
                    cnt_d = {1'b0, rd_entry_s[7:2]} + 7'd1;
                end else if (cnt_q != 7'd0) begin
                    cnt_d = cnt_q - 7'd1;
                end else begin
                    cnt_d = cnt_q;
                end
            end else begin
                data_out_d = data_out_q;
            end
        end
        pkt_busy_d = (cnt_d != 7'd0);
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= 9'h000;
            end
            wr_ptr_q   <= 5'd0;
            rd_ptr_q   <= 5'd0;
            cnt_q      <= 7'd0;
            data_out_q <= 8'h00;
            pkt_busy_q <= 1'b0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            data_out_q <= data_out_d;
            pkt_busy_q <= pkt_busy_d;
        end
    end

endmodule

// File: tb/tb_router_fifo.sv
// Directed self-checking bench for router_fifo; checks occupancy too when ROUTER_FIFO_OCC_EN is defined.
module tb_router_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       soft_reset = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic       lfd_state = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       full;
    logic       empty;
    logic       pkt_busy;
`ifdef ROUTER_FIFO_OCC_EN
    logic [4:0] occupancy;
`endif

    int vectors = 0;
    int miscompares = 0;

    router_fifo dut (
        .clk(clk), .rst(rst), .soft_reset(soft_reset), .wr_en(wr_en), .rd_en(rd_en),
        .lfd_state(lfd_state), .data_in(data_in), .data_out(data_out), .full(full),
        .empty(empty),
`ifdef ROUTER_FIFO_OCC_EN
        .occupancy(occupancy),
`endif
        .pkt_busy(pkt_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_occ(input string tag, input logic [4:0] exp);
`ifdef ROUTER_FIFO_OCC_EN
        chk(tag, {27'd0, occupancy}, {27'd0, exp});
`endif
    endtask

    task automatic wr(input logic lfd, input logic [7:0] d);
        wr_en = 1'b1; lfd_state = lfd; data_in = d;
        tick();
        wr_en = 1'b0; lfd_state = 1'b0;
    endtask

    task automatic rd();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    logic [7:0] pkt_bytes [5];
    logic       pkt_busy_exp [5];

    initial begin
        pkt_bytes    = '{8'h0C, 8'hA1, 8'hA2, 8'hA3, 8'h55};
        pkt_busy_exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        // Reset
        tick(); tick();
        rst = 1'b1;
        chk("rst_data_out", data_out, 8'h00);
        chk("rst_full", full, 1'b0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_pkt_busy", pkt_busy, 1'b0);
        chk_occ("rst_occ", 5'd0);

        // One packet: header 0C (length 3) + 3 payload + parity
        wr(1'b1, 8'h0C);
        for (int i = 1; i < 5; i++) wr(1'b0, pkt_bytes[i]);
        chk("pkt_empty", empty, 1'b0);
        chk_occ("pkt_occ", 5'd5);
        for (int i = 0; i < 5; i++) begin
            rd();
            chk($sformatf("pkt_data%0d", i), data_out, pkt_bytes[i]);
            chk($sformatf("pkt_busy%0d", i), pkt_busy, pkt_busy_exp[i]);
        end
        tick();
        chk("pkt_after_empty", empty, 1'b1);
        chk("pkt_after_busy", pkt_busy, 1'b0);
        chk("pkt_after_hold", data_out, 8'h55);

        // Fill to 16, drop 17th, drain in order
        for (int i = 0; i < 16; i++) wr(1'b0, 8'h10 + 8'(i));
        chk("fill_full", full, 1'b1);
        chk("fill_empty", empty, 1'b0);
        chk_occ("fill_occ", 5'd16);
        wr(1'b0, 8'hFF);
        chk("drop_full", full, 1'b1);
        chk_occ("drop_occ", 5'd16);
        for (int i = 0; i < 16; i++) begin
            rd();
            chk($sformatf("drain_data%0d", i), data_out, 8'h10 + 8'(i));
        end
        chk("drain_empty", empty, 1'b1);
        rd();
        chk("rd_empty_hold", data_out, 8'h1F);
        chk("rd_empty_still", empty, 1'b1);

        // Simultaneous read+write when full: only the read happens
        for (int i = 0; i < 16; i++) wr(1'b0, 8'h20 + 8'(i));
        wr_en = 1'b1; rd_en = 1'b1; data_in = 8'hEE;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("full_both_data", data_out, 8'h20);
        chk("full_both_full", full, 1'b0);
        chk_occ("full_both_occ", 5'd15);
        for (int i = 1; i < 16; i++) rd();
        chk("full_both_last", data_out, 8'h2F);
        chk("full_both_empty", empty, 1'b1);

        // Simultaneous read+write when empty: only the write happens
        wr_en = 1'b1; rd_en = 1'b1; data_in = 8'h77;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("empty_both_data", data_out, 8'h2F);
        chk("empty_both_empty", empty, 1'b0);
        rd();
        chk("empty_both_rd", data_out, 8'h77);
        chk("empty_both_after", empty, 1'b1);

        // soft_reset mid-packet: header 28 -> count 11; 7 entries remain; rd/wr ignored
        wr(1'b1, 8'h28);
        for (int i = 0; i < 7; i++) wr(1'b0, 8'h30 + 8'(i));
        rd();
        chk("sr_pre_busy", pkt_busy, 1'b1);
        chk_occ("sr_pre_occ", 5'd7);
        soft_reset = 1'b1; wr_en = 1'b1; rd_en = 1'b1; data_in = 8'h99;
        tick();
        soft_reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        chk("sr_empty", empty, 1'b1);
        chk("sr_busy", pkt_busy, 1'b0);
        chk("sr_data", data_out, 8'h00);
        chk_occ("sr_occ", 5'd0);

        // rst=0 together with soft_reset=1 behaves the same
        wr(1'b1, 8'h28);
        for (int i = 0; i < 7; i++) wr(1'b0, 8'h30 + 8'(i));
        rd();
        chk("rs_pre_busy", pkt_busy, 1'b1);
        rst = 1'b0; soft_reset = 1'b1; wr_en = 1'b1; rd_en = 1'b1;
        tick();
        rst = 1'b1; soft_reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        chk("rs_empty", empty, 1'b1);
        chk("rs_busy", pkt_busy, 1'b0);
        chk("rs_data", data_out, 8'h00);
        chk("rs_full", full, 1'b0);
        wr(1'b0, 8'h5A);
        rd();
        chk("rs_no_residual", pkt_busy, 1'b0);
        chk("rs_plain_data", data_out, 8'h5A);

        // 40 read+write pairs across pointer wrap, 3 entries kept in flight
        for (int i = 0; i < 3; i++) wr(1'b0, 8'h40 + 8'(i));
        for (int i = 0; i < 40; i++) begin
            wr_en = 1'b1; rd_en = 1'b1; data_in = 8'h43 + 8'(i);
            tick();
            chk($sformatf("wrap_data%0d", i), data_out, 8'h40 + 8'(i));
            chk($sformatf("wrap_flags%0d", i), {full, empty}, 2'b00);
            chk_occ($sformatf("wrap_occ%0d", i), 5'd3);
        end
        wr_en = 1'b0; rd_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rd();
            chk($sformatf("wrap_tail%0d", i), data_out, 8'h40 + 8'(40 + i));
        end
        chk("wrap_end_empty", empty, 1'b1);
        chk_occ("wrap_end_occ", 5'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/router_fifo.md
ROUTER_FIFO -- requirements
Module: router_fifo

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock.
REQ-002 SHALL have port rst  input  1  synchronous, active-low reset; clock clk.
REQ-003 SHALL have port soft_reset  input  1  per-port flush request from synchronizer, active-high, synchronous.
REQ-004 SHALL have port wr_en  input  1  write strobe for this output port.
REQ-005 SHALL have port rd_en  input  1  read strobe from the destination.
REQ-006 SHALL have port lfd_state  input  1  high when the byte on data_in is a packet header.
REQ-007 SHALL have port data_in  input  8  packet byte.
REQ-008 SHALL have port data_out  output  8  registered read data.
REQ-009 SHALL have port full  output  1  combinational, 16 entries occupied.
REQ-010 SHALL have port empty  output  1  combinational, 0 entries occupied.
REQ-011 SHALL have port pkt_busy  output  1  registered, high while the read side is inside a packet (remaining-byte count != 0).

Function
REQ-012 SHALL store 16 entries of 9 bits: {lfd_state, data_in}.
REQ-013 SHALL use 5-bit wr_ptr/rd_ptr (4 address bits + wrap bit); full = addresses equal and wrap bits differ; empty = pointers equal.
REQ-014 SHALL write mem[wr_ptr] and increment wr_ptr on a clock edge with wr_en=1 and full=0; wr_en with full=1 is dropped, no state change.
REQ-015 SHALL load data_out with mem[rd_ptr][7:0] and increment rd_ptr on a clock edge with rd_en=1 and empty=0; read latency 1 cycle; rd_en with empty=1 leaves data_out and rd_ptr unchanged.
REQ-016 SHALL evaluate full/empty from pre-edge pointers: simultaneous wr_en+rd_en when full performs only the read; when empty performs only the write; otherwise both, occupancy unchanged.
REQ-017 SHALL hold data_out at the last read value when no read occurs.
REQ-018 SHALL maintain a 7-bit remaining-byte counter: on a read of an entry whose bit 8 is 1, load mem[rd_ptr][7:2] + 1 (payload length plus parity byte); on a read of any other entry, decrement if nonzero, hold at 0 otherwise.
REQ-019 SHALL register pkt_busy = (next counter value != 0).
REQ-020 SHALL wrap pointers modulo 32 with no special handling at address 15 -> 0.

Reset
REQ-021 SHALL, when rst=0 at a clock edge, clear wr_ptr, rd_ptr, counter, all 16 entries, data_out=8'h00, pkt_busy=0; full=0, empty=1 after the edge.
REQ-022 SHALL, when rst=1 and soft_reset=1 at a clock edge, apply the same clearing as REQ-021 and ignore wr_en/rd_en that cycle.
REQ-023 SHALL give rst priority over soft_reset, soft_reset over read/write; reset mid-packet discards the packet with no residual count.

Configuration
REQ-024 SHALL, when macro ROUTER_FIFO_OCC_EN is defined, add output port occupancy  output  5  number of stored entries (0-16) = wr_ptr - rd_ptr modulo 32, combinational, 0 after reset or soft_reset.
REQ-025 SHALL, when ROUTER_FIFO_OCC_EN is undefined, have no occupancy port; all other behaviour identical.

Verification
REQ-026 SHALL cover: reset, then write header 8'h0C (lfd=1), payload 8'hA1,8'hA2,8'hA3, parity 8'h55; read 5 -> data_out 0C,A1,A2,A3,55 each one cycle after rd_en; pkt_busy high from the header read until the parity read, low afterwards.
REQ-027 SHALL cover: 16 writes with no reads -> full=1, empty=0; 17th write 8'hFF dropped; 16 reads return original order, then empty=1 and data_out holds last value.
REQ-028 SHALL cover: full FIFO with simultaneous wr_en+rd_en -> one read, write dropped, full=0 next cycle; empty FIFO with both -> one write, data_out unchanged, empty=0.
REQ-029 SHALL cover: soft_reset=1 for one cycle with 7 entries stored and pkt_busy=1 -> empty=1, pkt_busy=0, data_out=8'h00; rst=0 with soft_reset=1 behaves identically.
REQ-030 SHALL cover: 40 write/read pairs crossing pointer wrap -> data order preserved, no spurious full/empty; with ROUTER_FIFO_OCC_EN defined, occupancy tracks 0..16 throughout.
